// File: rtl/aabb_minmax_tracker.sv
// aabb_minmax_tracker: running IEEE-754 min/max over a batch of SAMPLES values on a stb/ack stream
module aabb_minmax_tracker #(
   parameter int SAMPLES = 8,
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_min,
   output logic [31:0] output_max,
   output logic        output_nan,
   output logic        output_z_stb,
   input  logic        output_z_ack
);
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] NEG_INF = 32'hFF800000;
   typedef enum logic [1:0] {get_a, classify, update, put_z} state_t;
   state_t state, state_n;
   logic [31:0] a, min_r, max_r;
   logic nan_r, nan_f, lt_f, gt_f;
   logic [CNT_W-1:0] count;
   logic take, give, last;
   // +0 and -0 compare equal; negative magnitudes order inversely
   function automatic logic less(input logic [31:0] x, input logic [31:0] y);
      return (x[31] != y[31]) ? x[31] && (x[30:0] != 0 || y[30:0] != 0)
                              : (x[31] ? x[30:0] > y[30:0] : x[30:0] < y[30:0]);
   endfunction
   assign take = input_a_ack && input_a_stb;
   assign give = output_z_stb && output_z_ack;
   assign last = count == CNT_W'(SAMPLES - 1);
   always_comb begin
      state_n = state;
      case (state)
         get_a:    state_n = take ? classify : get_a;
         classify: state_n = update;
         update:   state_n = last ? put_z : get_a;
         put_z:    state_n = give ? get_a : put_z;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= get_a;
         input_a_ack <= 1'b0;
         output_z_stb <= 1'b0;
         output_min <= '0;
         output_max <= '0;
         output_nan <= 1'b0;
         min_r <= POS_INF;
         max_r <= NEG_INF;
         nan_r <= 1'b0;
         count <= '0;
         a <= '0;
         nan_f <= 1'b0;
         lt_f <= 1'b0;
         gt_f <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            get_a: begin
               input_a_ack <= !take;
               if (take) a <= input_a;
            end
            classify: begin
               nan_f <= a[30:23] == 8'hFF && a[22:0] != 0;
               lt_f <= less(a, min_r);
               gt_f <= less(max_r, a);
            end
            update: begin
               if (nan_f) nan_r <= 1'b1;
               else begin
                  if (lt_f) min_r <= a;
                  if (gt_f) max_r <= a;
               end
               if (!last) count <= count + CNT_W'(1);
            end
            put_z: begin
               output_z_stb <= !give;
               output_min <= min_r;
               output_max <= max_r;
               output_nan <= nan_r;
               if (give) begin
                  min_r <= POS_INF;
                  max_r <= NEG_INF;
                  nan_r <= 1'b0;
                  count <= '0;
               end
            end
         endcase
      end
   end
endmodule
